pipe_stage_hs: RTL
==================

Name: pipe_stage_hs

Overview:
- Parametrised handshaked pipeline-stage register; next generation of the fixed load-enabled inter-stage flip-flop banks (if/id, id/ex, ex/mem, mem/wb).
- Carries one packed payload (control word plus datapath fields) of arbitrary width between two pipeline stages using valid/ready flow control.
- Supports flush/bubble insertion with a programmable NOP payload, an optional 2-entry skid mode for a registered in_ready, and a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 16, payload width in bits. Legal range is 1 or more; the control-word instance uses 43 or more.
- NOP_VALUE, '0, payload value driven on out_data after reset and after flush.
- SKID, 1, 1 selects the 2-entry skid buffer with a registered in_ready; 0 selects a single register with a combinational in_ready.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream stage has a payload.
- in_ready  out  1  this stage accepts the payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live payload.
- out_ready  in  1  downstream stage consumes the payload this cycle.
- out_data  out  WIDTH  payload to the downstream stage; registered, no combinational path from in_data.
- flush  in  1  kill all held payloads (branch mispredict, trap).
- stat_clear  in  1  synchronously zero the stall counter.
- stall_cnt  out  CNT_WIDTH  number of cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payloads transfer only on fire. in_data is don't-care when in_valid=0.
- Reset (one edge with reset=1):
  - State goes to EMPTY, out_valid=0, out_data=NOP_VALUE, skid register=NOP_VALUE, stall_cnt=0.
  - in_ready is forced to 0 while reset=1.
  - Reset overrides flush, stat_clear and any handshake in the same cycle.
  - A payload offered during the reset cycle is dropped.
- SKID=1 state machine (state is the held-entry count):
  - EMPTY: out_valid=0, in_ready=1. On in_fire go to FULL with main<=in_data.
  - FULL: out_valid=1, in_ready=1.
    - in_fire & out_fire: stay in FULL, main<=in_data.
    - in_fire & !out_fire: go to SKID, skid<=in_data.
    - !in_fire & out_fire: go to EMPTY.
    - Otherwise hold.
  - SKID: out_valid=1, in_ready=0. On out_fire go to FULL with main<=skid. Otherwise hold.
  - in_ready is a function of the state register only. It has no combinational dependence on out_ready.
  - Ordering is FIFO: main is always older than skid.
  - Latency is 1 cycle from in_fire to out_valid when empty.
  - Sustained throughput is 1 payload per cycle while out_ready=1.
- SKID=0:
  - Single register. in_ready = !reset & (!out_valid | out_ready), which is combinational.
  - On in_fire: main<=in_data and out_valid<=1.
  - On out_fire without in_fire: out_valid<=0.
  - Latency is 1 cycle. Throughput is 1 payload per cycle.
- out_data when empty: on any transition into EMPTY, main<=NOP_VALUE, so a downstream stage ignoring out_valid sees a NOP.
- Flush (reset=0):
  - Next state is EMPTY, out_valid=0, main<=NOP_VALUE, skid<=NOP_VALUE.
  - A payload accepted (in_fire) in the same cycle as flush is discarded.
  - An out_fire in the flush cycle still completes, because the downstream stage sampled it.
  - in_ready is not gated by flush.
- Stall counter:
  - Increments each cycle with out_valid & !out_ready, reset=0 and stat_clear=0.
  - Holds at 2^CNT_WIDTH-1 (saturates, no wrap).
  - stat_clear wins over increment.
  - flush does not affect the counter.
- Payload is opaque; no width conversion. All WIDTH bits are stored and forwarded unchanged.

Test Plan:
- Fill/drain, SKID=1, WIDTH=16, out_ready=1: drive in_data 0x1000..0x1004 on consecutive cycles -> out_data shows 0x1000..0x1004 one cycle later, back-to-back; in_ready stays 1; stall_cnt=0.
- Backpressure into skid: send 0xAAAA, then 0xBBBB while out_ready=0 -> state SKID, in_ready=0 on the next cycle, 0xCCCC is held upstream; release out_ready -> outputs 0xAAAA, 0xBBBB, 0xCCCC in order with no loss or duplication; stall_cnt equals the number of stalled cycles.
- Flush with simultaneous input, SKID=1, NOP_VALUE=0x0000, stage in SKID state: assert flush together with in_valid=1, in_data=0x5555 -> next cycle out_valid=0, out_data=0x0000, in_ready=1; 0x5555 never appears on out_data.
- Counter saturation, CNT_WIDTH=3: hold out_valid=1 with out_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds at 7; pulse stat_clear -> 0 next cycle; stat_clear concurrent with a stall -> 0.
- SKID=0, WIDTH=43: with out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle; a simultaneous in_fire and out_fire replaces main with no bubble; single-register occupancy is never exceeded.
- Reset mid-operation: stage in SKID state with stall_cnt=5, assert reset together with flush, stat_clear and in_valid -> next cycle out_valid=0, out_data=NOP_VALUE, stall_cnt=0; in_ready=0 while reset=1 and 1 on the first cycle after.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register with flush/NOP insertion, optional
// 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_hs #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1,
  parameter int unsigned      CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 flush,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // State is the number of held entries; ST_SKID is only reachable with SKID=1.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     main_q;
  logic [WIDTH-1:0]     main_nxt;
  logic [WIDTH-1:0]     skid_q;
  logic [WIDTH-1:0]     skid_nxt;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 in_fire;
  logic                 out_fire;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Upstream ready: state-only in skid mode, pass-through of out_ready otherwise.
  always_comb begin
    if (SKID) begin
      in_ready = !reset && (state != ST_SKID);
    end else begin
      in_ready = !reset && (!out_valid || out_ready);
    end
  end

  // Next-state and payload steering; main is always the older entry.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = NOP_VALUE;
      skid_nxt  = NOP_VALUE;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt = ST_FULL;
            main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            // Only reachable with SKID=1: single-register mode cannot accept
            // while full unless the held payload leaves in the same cycle.
            state_nxt = ST_SKID;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
            main_nxt  = NOP_VALUE;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_nxt = ST_FULL;
            main_nxt  = skid_q;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          main_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // Saturating count of cycles where a live payload is held back downstream.
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule
